led_fade_sequencer: RTL and testbench
=====================================

LED_FADE_SEQUENCER -- requirements
Module: led_fade_sequencer

Interface
REQ-001 SHALL have parameter parm_color_led_count, default 4: number of three-filament color LEDs.
REQ-002 SHALL have parameter parm_basic_led_count, default 4: number of single-filament basic LEDs.
REQ-003 SHALL have parameter parm_FCLK, default 40_000_000: i_clk frequency in Hz.
REQ-004 SHALL have parameter parm_step_milliseconds, default 2: interval between fade steps.
REQ-005 SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_srst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports i_target_red, i_target_green, i_target_blue  in  8*parm_color_led_count each  target palette; LED k uses bits [8k+7:8k].
REQ-008 SHALL have port i_target_lumin  in  8*parm_basic_led_count  target luminance, same packing.
REQ-009 SHALL have port i_load  in  1  single-cycle request to start a fade to the present targets.
REQ-010 SHALL have ports o_color_led_red_value, o_color_led_green_value, o_color_led_blue_value  out  8*parm_color_led_count each  current palette to the PWM driver, same packing.
REQ-011 SHALL have port o_basic_led_lumin_value  out  8*parm_basic_led_count  current luminance to the PWM driver.
REQ-012 SHALL have port o_busy  out  1  high while a fade is in progress.
REQ-013 SHALL have port o_done  out  1  one-cycle pulse when a fade completes.

Function
REQ-014 SHALL define c_step_cycles = parm_FCLK/1000*parm_step_milliseconds (integer math); c_step_cycles >= 1 is required.
REQ-015 SHALL implement FSM states IDLE, FADE, DONE; reset state is IDLE.
REQ-016 SHALL accept i_load only in IDLE: on that cycle, register all targets, load the step counter with c_step_cycles-1, and enter FADE on the next cycle.
REQ-017 SHALL ignore i_load in FADE and DONE; the captured targets are not altered.
REQ-018 SHALL decrement the step counter in FADE each cycle it is nonzero; at zero, reload it with c_step_cycles-1 and perform one step.
REQ-019 SHALL, on a step, move each 8-bit channel independently by 1 toward its captured target: +1 if below, -1 if above, unchanged if equal; no wrap past 0 or 255.
REQ-020 SHALL make stepped values visible on outputs the cycle after the step cycle.
REQ-021 SHALL transition FADE->DONE when every channel's registered output equals its captured target, evaluated each FADE cycle and taking priority over a step on the same cycle.
REQ-022 SHALL hold DONE for exactly one cycle with o_done=1, then enter IDLE.
REQ-023 SHALL drive o_busy=1 in FADE and DONE, and 0 in IDLE.
REQ-024 SHALL hold output values constant in IDLE and DONE.
REQ-025 SHALL, when i_load occurs with targets already equal to outputs, pass FADE for one cycle, then DONE, with no value change.
REQ-026 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while i_srst=1, set all value outputs to 8'h00, o_busy=0, o_done=0, state IDLE, step counter c_step_cycles-1, captured targets 0.
REQ-028 SHALL abort any fade on i_srst mid-operation, with the reset values visible the cycle after i_srst is sampled high.
REQ-029 SHALL give i_srst priority over i_load on the same cycle.

Verification (parm_color_led_count=2, parm_basic_led_count=2, parm_FCLK=1000, parm_step_milliseconds=4, so c_step_cycles=4)
REQ-030 SHALL cover reset: i_srst=1 for 2 cycles -> all values 0, o_busy=0, o_done=0.
REQ-031 SHALL cover fade up: i_load at cycle t with red LED0 target 3, others 0 -> red LED0 reads 1 at t+5, 2 at t+9, 3 at t+13; o_done=1 at t+14 only; o_busy high t+1..t+14.
REQ-032 SHALL cover mixed direction: from green LED1=5 and lumin LED0=0, load green LED1 target 2 and lumin LED0 target 2 -> green goes 4,3,2 while lumin goes 1,2 on the same step cycles; done after green reaches 2.
REQ-033 SHALL cover ignored load: i_load with new targets at t+6 of an active fade -> fade continues to the original targets; the new targets are never applied.
REQ-034 SHALL cover null fade: i_load with targets equal to outputs at t -> o_busy high t+1..t+2; o_done at t+2; values unchanged.
REQ-035 SHALL cover reset mid-fade: i_srst at t+7 of the fade-up scenario -> values 0, o_busy=0 at t+8; no o_done pulse.

Source files
------------

// File: rtl/led_fade_sequencer.sv
// rtl/led_fade_sequencer.sv - fades LED palette and luminance values one step at a time toward captured targets
//
// Ports:
//   i_clk                     sole clock, rising edge
//   i_srst                    synchronous active-high reset
//   i_target_red/green/blue   target palette, LED k in bits [8k+7:8k]
//   i_target_lumin            target basic-LED luminance, same packing
//   i_load                    single-cycle fade request, honoured only when idle
//   o_color_led_*_value       current palette to the PWM driver
//   o_basic_led_lumin_value   current luminance to the PWM driver
//   o_busy                    high while a fade (including its done cycle) is in progress
//   o_done                    one-cycle pulse when a fade completes
module led_fade_sequencer #(
    parameter int parm_color_led_count   = 4,
    parameter int parm_basic_led_count   = 4,
    parameter int parm_FCLK              = 40_000_000,
    parameter int parm_step_milliseconds = 2
) (
    input  logic                              i_clk,
    input  logic                              i_srst,
    input  logic [8*parm_color_led_count-1:0] i_target_red,
    input  logic [8*parm_color_led_count-1:0] i_target_green,
    input  logic [8*parm_color_led_count-1:0] i_target_blue,
    input  logic [8*parm_basic_led_count-1:0] i_target_lumin,
    input  logic                              i_load,
    output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
    output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
    output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
    output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int c_step_cycles = parm_FCLK / 1000 * parm_step_milliseconds;
    localparam int c_nc          = parm_color_led_count;
    localparam int c_chan        = 3 * parm_color_led_count + parm_basic_led_count;
    localparam int c_cnt_w       = (c_step_cycles > 1) ? $clog2(c_step_cycles) : 1;
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(c_step_cycles - 1);

    typedef enum logic [1:0] {IDLE, FADE, DONE} state_t;

    state_t               state;
    logic [c_cnt_w-1:0]   step_cnt;
    // All channels are kept in one flat vector: red, green, blue, lumin from LSB up.
    logic [8*c_chan-1:0]  cur;
    logic [8*c_chan-1:0]  tgt;
    logic [8*c_chan-1:0]  stepped;

    // Each channel moves by one toward its target; equal channels stay put,
    // so no channel can wrap past 0 or 255.
    always_comb begin
        stepped = cur;
        for (int i = 0; i < c_chan; i++) begin
            if (cur[8*i +: 8] < tgt[8*i +: 8]) begin
                stepped[8*i +: 8] = cur[8*i +: 8] + 8'd1;
            end else if (cur[8*i +: 8] > tgt[8*i +: 8]) begin
                stepped[8*i +: 8] = cur[8*i +: 8] - 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state    <= IDLE;
            step_cnt <= c_reload;
            cur      <= '0;
            tgt      <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_load) begin
                        tgt      <= {i_target_lumin, i_target_blue, i_target_green, i_target_red};
                        step_cnt <= c_reload;
                        state    <= FADE;
                        o_busy   <= 1'b1;
                    end
                end
                FADE: begin
                    // Arrival wins over a step due on the same cycle.
                    if (cur == tgt) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else if (step_cnt != '0) begin
                        step_cnt <= step_cnt - 1'b1;
                    end else begin
                        step_cnt <= c_reload;
                        cur      <= stepped;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_color_led_red_value   = cur[0*8*c_nc +: 8*c_nc];
    assign o_color_led_green_value = cur[1*8*c_nc +: 8*c_nc];
    assign o_color_led_blue_value  = cur[2*8*c_nc +: 8*c_nc];
    assign o_basic_led_lumin_value = cur[3*8*c_nc +: 8*parm_basic_led_count];

endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb/tb_led_fade_sequencer.sv - self-checking bench for led_fade_sequencer
module tb_led_fade_sequencer;

    localparam int NC   = 2;
    localparam int NB   = 2;
    localparam int STEP = 4;
    localparam int NCH  = 3 * NC + NB;

    logic            clk;
    logic            srst;
    logic            load;
    logic [8*NC-1:0] t_red, t_green, t_blue;
    logic [8*NB-1:0] t_lumin;
    logic [8*NC-1:0] v_red, v_green, v_blue;
    logic [8*NB-1:0] v_lumin;
    logic            busy, done;

    led_fade_sequencer #(
        .parm_color_led_count  (NC),
        .parm_basic_led_count  (NB),
        .parm_FCLK             (1000),
        .parm_step_milliseconds(4)
    ) dut (
        .i_clk                  (clk),
        .i_srst                 (srst),
        .i_target_red           (t_red),
        .i_target_green         (t_green),
        .i_target_blue          (t_blue),
        .i_target_lumin         (t_lumin),
        .i_load                 (load),
        .o_color_led_red_value  (v_red),
        .o_color_led_green_value(v_green),
        .o_color_led_blue_value (v_blue),
        .o_basic_led_lumin_value(v_lumin),
        .o_busy                 (busy),
        .o_done                 (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a fade accepted at cycle t with largest channel distance D
    // shows floor((n-1)/STEP) steps (capped at D) in cycle t+n, is busy for
    // t+1..t+STEP*D+2 and pulses done at t+STEP*D+2.
    logic [7:0] m_start[NCH];
    logic [7:0] m_tgt[NCH];
    logic [7:0] m_val[NCH];
    int         m_k, m_d;
    bit         m_act, m_busy, m_done;

    logic [63:0] s_vals;
    logic        s_busy, s_done;

    function automatic logic [63:0] pack(input logic [7:0] r0, r1, g0, g1, b0, b1, l0, l1);
        return {l1, l0, b1, b0, g1, g0, r1, r0};
    endfunction

    function automatic logic [7:0] moved(input logic [7:0] s, input logic [7:0] t, input int k);
        int d;
        d = (s < t) ? int'(t) - int'(s) : int'(s) - int'(t);
        if (k < d) d = k;
        return (s < t) ? 8'(int'(s) + d) : 8'(int'(s) - d);
    endfunction

    function automatic logic [63:0] m_flat();
        logic [63:0] f;
        for (int i = 0; i < NCH; i++) f[8*i +: 8] = m_val[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_start[i] = 8'd0; m_tgt[i] = 8'd0; m_val[i] = 8'd0;
        end
        m_act = 0; m_busy = 0; m_done = 0; m_k = 0; m_d = 0;
    endtask

    task automatic model_eval();
        int s;
        s = (m_k - 1) / STEP;
        if (s > m_d) s = m_d;
        for (int i = 0; i < NCH; i++) m_val[i] = moved(m_start[i], m_tgt[i], s);
        m_busy = 1;
        m_done = (m_k == STEP * m_d + 2);
    endtask

    task automatic model_update(input bit r, input bit l, input logic [63:0] tv);
        int d;
        if (r) begin
            model_reset();
        end else if (m_act) begin
            m_k++;
            if (m_k > STEP * m_d + 2) begin
                m_act = 0; m_busy = 0; m_done = 0;
            end else begin
                model_eval();
            end
        end else if (l) begin
            m_d = 0;
            for (int i = 0; i < NCH; i++) begin
                m_start[i] = m_val[i];
                m_tgt[i]   = tv[8*i +: 8];
                d = (m_start[i] < m_tgt[i]) ? int'(m_tgt[i]) - int'(m_start[i])
                                            : int'(m_start[i]) - int'(m_tgt[i]);
                if (d > m_d) m_d = d;
            end
            m_act = 1; m_k = 1;
            model_eval();
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drives one cycle of inputs, compares the DUT with the model mid-cycle,
    // then advances the model and the clock.
    task automatic tick(input bit r, input bit l, input logic [63:0] tv);
        srst = r;
        load = l;
        {t_lumin, t_blue, t_green, t_red} = tv;
        @(negedge clk);
        s_vals = {v_lumin, v_blue, v_green, v_red};
        s_busy = busy;
        s_done = done;
        check("model_values", s_vals, m_flat());
        check("model_busy", 64'(s_busy), 64'(m_busy));
        check("model_done", 64'(s_done), 64'(m_done));
        model_update(r, l, tv);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         load;
        logic [7:0] red0_tgt;
        logic [7:0] exp_red0;
        bit         exp_busy;
        bit         exp_done;
    } vec_t;

    vec_t        tbl[16];
    logic [63:0] z;
    logic [63:0] saved;
    int          done_seen;
    bit          got;

    initial begin
        z = 64'd0;
        for (int i = 0; i < 16; i++) begin
            tbl[i].load     = (i == 0);
            tbl[i].red0_tgt = 8'd3;
            tbl[i].exp_red0 = (i <= 4) ? 8'd0 : (i <= 8) ? 8'd1 : (i <= 12) ? 8'd2 : 8'd3;
            tbl[i].exp_busy = (i >= 1) && (i <= 14);
            tbl[i].exp_done = (i == 14);
        end

        srst = 1'b1; load = 1'b0;
        t_red = '0; t_green = '0; t_blue = '0; t_lumin = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        tick(0, 0, z);
        check("reset_values", s_vals, 64'd0);
        check("reset_busy", 64'(s_busy), 64'd0);
        check("reset_done", 64'(s_done), 64'd0);

        // Fade up, table driven
        for (int i = 0; i < 16; i++) begin
            tick(0, tbl[i].load, pack(tbl[i].red0_tgt, 0, 0, 0, 0, 0, 0, 0));
            check($sformatf("up_red0_%0d", i), 64'(s_vals[7:0]), 64'(tbl[i].exp_red0));
            check($sformatf("up_busy_%0d", i), 64'(s_busy), 64'(tbl[i].exp_busy));
            check($sformatf("up_done_%0d", i), 64'(s_done), 64'(tbl[i].exp_done));
        end

        // Mixed direction: bring green LED1 to 5 first
        tick(0, 1, pack(3, 0, 0, 5, 0, 0, 0, 0));
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick(0, 0, z);
            got = s_done;
        end
        check("setup_done_seen", 64'(got), 64'd1);
        tick(0, 0, z);
        tick(0, 1, pack(3, 0, 0, 2, 0, 0, 2, 0));
        for (int i = 1; i <= 14; i++) begin
            tick(0, 0, z);
            if (i == 5)  check("mix_t5",  {48'd0, s_vals[31:24], s_vals[55:48]}, {48'd0, 8'd4, 8'd1});
            if (i == 9)  check("mix_t9",  {48'd0, s_vals[31:24], s_vals[55:48]}, {48'd0, 8'd3, 8'd2});
            if (i == 13) check("mix_t13", {48'd0, s_vals[31:24], s_vals[55:48]}, {48'd0, 8'd2, 8'd2});
            if (i == 14) check("mix_done", 64'(s_done), 64'd1);
        end
        tick(0, 0, z);

        // Ignored load mid-fade
        tick(0, 1, pack(0, 0, 0, 2, 0, 0, 2, 0));
        for (int i = 1; i <= 14; i++) begin
            tick(0, (i == 6), pack(200, 9, 7, 7, 7, 7, 7, 7));
            if (i == 14) begin
                check("ign_done", 64'(s_done), 64'd1);
                check("ign_values", s_vals, pack(0, 0, 0, 2, 0, 0, 2, 0));
            end
        end
        tick(0, 0, z);

        // Null fade
        saved = s_vals;
        tick(0, 1, pack(0, 0, 0, 2, 0, 0, 2, 0));
        tick(0, 0, z);
        check("null_busy1", 64'(s_busy), 64'd1);
        check("null_done1", 64'(s_done), 64'd0);
        tick(0, 0, z);
        check("null_busy2", 64'(s_busy), 64'd1);
        check("null_done2", 64'(s_done), 64'd1);
        check("null_values", s_vals, saved);
        tick(0, 0, z);
        check("null_idle", 64'(s_busy), 64'd0);

        // Reset mid-fade, asserted together with a load request
        tick(0, 1, pack(3, 0, 0, 2, 0, 0, 2, 0));
        for (int i = 1; i <= 6; i++) tick(0, 0, z);
        tick(1, 1, pack(9, 9, 9, 9, 9, 9, 9, 9));
        tick(0, 0, z);
        check("rst_mid_values", s_vals, 64'd0);
        check("rst_mid_busy", 64'(s_busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, z);
            done_seen += int'(s_done);
        end
        check("rst_mid_no_done", 64'(done_seen), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 6000; n++) begin
            logic [63:0] tv;
            for (int i = 0; i < NCH; i++)
                tv[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(0, 12));
            tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0), tv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
